// File: rtl/vld_pkg.sv
// Shared types and constants for the OR1200 JPEG variable-length decode front end.
package vld_pkg;

  localparam int unsigned BUF_W      = 32;
  localparam int unsigned PEEK_W     = 16;
  localparam int unsigned ACCEPT_MAX = 24;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [7:0] STUFF_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF_ZERO   = 8'h00;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SAW_FF = 2'd1,
    MARKER = 2'd2
  } vld_state_t;

endpackage

// File: rtl/or1200_vld_ctrl_if.sv
// Stream, peek/consume and marker signals between the byte source/decoder and the VLD front end.
interface or1200_vld_ctrl_if;
  import vld_pkg::*;

  logic [BYTE_W-1:0] byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic [PEEK_W-1:0] peek_o;
  logic [CNT_W-1:0]  avail_o;
  logic              consume_i;
  logic [LEN_W-1:0]  consume_len_i;
  logic              clear_i;
  logic              marker_o;
  logic [BYTE_W-1:0] marker_code_o;
  logic              marker_ack_i;
  logic              err_o;

  modport slave (
    input  byte_i, byte_valid_i, consume_i, consume_len_i, clear_i, marker_ack_i,
    output byte_ready_o, peek_o, avail_o, marker_o, marker_code_o, err_o
  );

  modport master (
    output byte_i, byte_valid_i, consume_i, consume_len_i, clear_i, marker_ack_i,
    input  byte_ready_o, peek_o, avail_o, marker_o, marker_code_o, err_o
  );
endinterface

// File: rtl/or1200_vld_destuff.sv
// Byte destuffing FSM: strips 0xFF/0x00 stuffing, drops fill bytes, latches markers.
module or1200_vld_destuff
  import vld_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              marker_ack_i,
  output vld_state_t        state_o,
  output logic              append_valid_o,
  output logic [BYTE_W-1:0] append_byte_o,
  output logic              marker_o,
  output logic [BYTE_W-1:0] marker_code_o
);

  vld_state_t        state_q, state_d;
  logic              marker_q, marker_d;
  logic [BYTE_W-1:0] code_q, code_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= NORMAL;
      marker_q <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      marker_q <= marker_d;
      code_q   <= code_d;
    end
  end

  // append_* are same-cycle strobes into the shift buffer
  always_comb begin
    state_d        = state_q;
    marker_d       = marker_q;
    code_d         = code_q;
    append_valid_o = 1'b0;
    append_byte_o  = byte_i;
    if (clear_i) begin
      state_d  = NORMAL;
      marker_d = 1'b0;
    end else begin
      unique case (state_q)
        NORMAL: begin
          if (take_i) begin
            if (byte_i == STUFF_PREFIX) state_d = SAW_FF;
            else                        append_valid_o = 1'b1;
          end
        end
        SAW_FF: begin
          if (take_i) begin
            if (byte_i == STUFF_ZERO) begin
              append_valid_o = 1'b1;
              append_byte_o  = STUFF_PREFIX;
              state_d        = NORMAL;
            end else if (byte_i != STUFF_PREFIX) begin
              code_d   = byte_i;
              marker_d = 1'b1;
              state_d  = MARKER;
            end
          end
        end
        MARKER: begin
          if (marker_ack_i) begin
            marker_d = 1'b0;
            state_d  = NORMAL;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  assign state_o       = state_q;
  assign marker_o      = marker_q;
  assign marker_code_o = code_q;

endmodule

// File: rtl/or1200_vld_ctrl.sv
// VLD front end: destuffed bytes fill an MSB-aligned bit buffer that the decoder peeks and consumes.
module or1200_vld_ctrl
  import vld_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  or1200_vld_ctrl_if.slave     bus
);

  logic [BUF_W-1:0]  buf_q, buf_d, buf_sh;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sh;
  logic              err_q, err_d;
  logic              byte_take, cons_req, cons_ok, cons_bad;
  logic              app_valid;
  logic [BYTE_W-1:0] app_byte;
  vld_state_t        state;

  assign bus.byte_ready_o = (state != MARKER) && (cnt_q <= CNT_W'(ACCEPT_MAX));
  assign byte_take        = bus.byte_valid_i && bus.byte_ready_o && !bus.clear_i;

  assign cons_req = bus.consume_i && (bus.consume_len_i != '0);
  assign cons_ok  = cons_req && (bus.consume_len_i <= LEN_W'(PEEK_W))
                             && (CNT_W'(bus.consume_len_i) <= cnt_q);
  assign cons_bad = cons_req && !cons_ok;

  or1200_vld_destuff u_destuff (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (bus.clear_i),
    .take_i         (byte_take),
    .byte_i         (bus.byte_i),
    .marker_ack_i   (bus.marker_ack_i),
    .state_o        (state),
    .append_valid_o (app_valid),
    .append_byte_o  (app_byte),
    .marker_o       (bus.marker_o),
    .marker_code_o  (bus.marker_code_o)
  );

  // Consume first, then drop the new byte directly below the surviving bits
  always_comb begin
    buf_sh = buf_q;
    cnt_sh = cnt_q;
    if (cons_ok) begin
      buf_sh = buf_q << bus.consume_len_i;
      cnt_sh = cnt_q - CNT_W'(bus.consume_len_i);
    end
    buf_d = buf_sh;
    cnt_d = cnt_sh;
    err_d = err_q | cons_bad;
    if (app_valid) begin
      buf_d = buf_sh | ({app_byte, {(BUF_W-BYTE_W){1'b0}}} >> cnt_sh);
      cnt_d = cnt_sh + CNT_W'(BYTE_W);
    end
    if (bus.clear_i) begin
      buf_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.peek_o  = buf_q[BUF_W-1 -: PEEK_W];
  assign bus.avail_o = cnt_q;
  assign bus.err_o   = err_q;

endmodule
